tod_pps_gen: RTL and testbench
==============================

Name: tod_pps_gen

Overview:
Downstream consumer of tod_core: watches the running time-of-day (ns and sec fields) and generates a 1PPS-style output pulse at a programmable phase within the second, every 2^N seconds, with a programmable width.
Also emits a one-cycle event strobe with the captured second and the edge lateness, which drives timestamp and phase-compensation logic.
Sits between tod_core and the board PPS output pin or SMA driver.

Parameters:
TIME_WIDTH_NS, 32, width of ns field
TIME_WIDTH_SEC, 48, width of sec field
NS_PER_SEC, 1000000000, ns field rollover value

Ports:
clk  in  1  system clock; same clock domain as tod_core
rst  in  1  asynchronous active-high reset
tod_vld  in  1  tod_ns/tod_sec valid this cycle
tod_ns  in  TIME_WIDTH_NS  current ns field, 0..NS_PER_SEC-1
tod_sec  in  TIME_WIDTH_SEC  current sec field
tod_jump  in  1  one-cycle flag; ToD was set, offset or stepped this cycle
pps_en  in  1  enable
pps_phase_ns  in  TIME_WIDTH_NS  edge position within the second
pps_width_ns  in  TIME_WIDTH_NS  pulse high time
pps_period_log2  in  3  period = 2^N seconds
pps_out  out  1  pulse output, registered
pps_evt  out  1  one-cycle strobe on rising edge of pps_out
pps_sec  out  TIME_WIDTH_SEC  tod_sec at trigger
pps_late_ns  out  TIME_WIDTH_NS  tod_ns minus pps_phase_ns at trigger (mod NS_PER_SEC)
cfg_err  out  1  configuration illegal

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; prev_ns and prev_sec 0; prev_ok 0.
- prev_ns, prev_sec and prev_ok hold the last valid sample. prev_ok clears on tod_jump and in IDLE.
- cfg_err is combinational from config: 1 if phase >= NS_PER_SEC, width == 0, or width >= NS_PER_SEC.
- Crossing detection on a tod_vld cycle with prev_ok=1 and tod_jump=0. A crossing exists when either condition holds:
  - sec == prev_sec+1 and ns >= phase
  - sec == prev_sec, prev_ns < phase and ns >= phase
- Backward steps, forward steps of more than 1 s, and tod_jump cycles never trigger. Detection re-arms on the next valid sample.
- Trigger = crossing AND (sec & ((1<<period_log2)-1)) == 0.
- FSM IDLE:
  - pps_out=0.
  - Go to ARMED when pps_en=1 and cfg_err=0.
- FSM ARMED:
  - On trigger, go to HIGH.
  - In the next cycle: pps_out=1, pps_evt=1, pps_sec=sec, pps_late_ns=ns-phase. Total latency is 1 clk from the sampled crossing.
  - Latch end time. end_ns = phase+width, computed in TIME_WIDTH_NS+1 bits. If end_ns >= NS_PER_SEC, subtract NS_PER_SEC and set end_sec = sec+1; otherwise end_sec = sec.
- FSM HIGH:
  - pps_out stays 1.
  - Return to ARMED (pps_out=0 next cycle) when the valid sample satisfies (sec,ns) >= (end_sec,end_ns), compared lexicographically.
  - Also return to ARMED on tod_jump.
  - A new trigger in HIGH restarts the pulse: pps_evt fires again and a new end time is latched.
- pps_en=0 or cfg_err=1 in any state: go to IDLE next cycle; pps_out drops immediately (registered).
- Config is sampled only at the trigger. Mid-pulse changes to width or phase do not affect the current pulse.
- tod_vld=0: no state change except the enable/err exit; prev_* held.
- pps_evt is never high for more than 1 consecutive cycle.

Decomposition:
- Package tod_pkg holds:
  - NS_PER_SEC
  - the field-width constants, shared with tod_core
  - the FSM state enum {IDLE, ARMED, HIGH}
- One sub-module, tod_cmp: lexicographic (sec,ns) >= compare, plus the crossing detector. It is reused by future alarm and timestamp blocks.

Test Plan:
- Basic crossing: phase=500000000, width=100000000, log2=0; ToD steps 8 ns from sec=5, ns=499999992 -> pps_out rises 1 clk after sample ns=500000000; pps_sec=5, pps_late_ns=0; falls 1 clk after ns=600000000.
- Pulse across second boundary: phase=999999000, width=2000 -> end latched at sec+1, ns=1000; pulse spans the rollover; single pps_evt.
- Rollover trigger with late sample: phase=0, samples ns=999999996 then sec+1, ns=4 -> trigger, pps_late_ns=4.
- Period gating: log2=2, run seconds 0..9 -> evt only at sec 0, 4 and 8.
- Jump: tod_jump with a backward step from sec=10, ns=700000000 to sec=10, ns=100000000 -> no trigger, pulse (if high) drops; next crossing at ns=500000000 fires normally.
- Config and enable: width=0 -> cfg_err=1, no output. pps_en dropped mid-pulse -> pps_out=0 next clk, state IDLE. rst asserted mid-pulse -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tod_pkg.sv
// tod_pkg: constants shared by the time-of-day blocks (tod_core and its
// downstream consumers).
//   TIME_WIDTH_NS  : width of the nanosecond field
//   TIME_WIDTH_SEC : width of the seconds field
//   NS_PER_SEC     : nanosecond field rollover value
//   IDLE/ARMED/HIGH: PPS generator FSM state encodings
package tod_pkg;

  localparam int     TIME_WIDTH_NS  = 32;
  localparam int     TIME_WIDTH_SEC = 48;
  localparam longint NS_PER_SEC     = 1000000000;

  // FSM encodings kept as plain constants so older blocks that compare
  // against raw 2-bit codes keep working.
  typedef logic [1:0] pps_state_t;
  localparam pps_state_t IDLE  = 2'd0;
  localparam pps_state_t ARMED = 2'd1;
  localparam pps_state_t HIGH  = 2'd2;

endpackage

// File: rtl/tod_cmp.sv
// tod_cmp: time-of-day comparison helpers, shared by PPS, alarm and
// timestamp blocks.
//   cur_sec/cur_ns   : current ToD sample
//   ref_sec/ref_ns   : reference time for the >= compare
//   cur_ge_ref       : (cur_sec,cur_ns) >= (ref_sec,ref_ns), lexicographic
//   prev_sec/prev_ns : previous valid sample
//   prev_ok          : previous sample is usable for crossing detection
//   sample_ok        : current sample is valid and not a ToD jump
//   phase_ns         : position within the second being watched
//   crossing         : the ToD passed phase_ns between prev and cur
module tod_cmp #(
  parameter int TIME_WIDTH_NS  = 32,
  parameter int TIME_WIDTH_SEC = 48
) (
  input  logic [TIME_WIDTH_SEC-1:0] cur_sec,
  input  logic [TIME_WIDTH_NS-1:0]  cur_ns,
  input  logic [TIME_WIDTH_SEC-1:0] ref_sec,
  input  logic [TIME_WIDTH_NS-1:0]  ref_ns,
  output logic                      cur_ge_ref,
  input  logic [TIME_WIDTH_SEC-1:0] prev_sec,
  input  logic [TIME_WIDTH_NS-1:0]  prev_ns,
  input  logic                      prev_ok,
  input  logic                      sample_ok,
  input  logic [TIME_WIDTH_NS-1:0]  phase_ns,
  output logic                      crossing
);

  logic [TIME_WIDTH_SEC-1:0] prev_sec_inc;
  logic                      same_sec_cross;
  logic                      next_sec_cross;

  assign cur_ge_ref = (cur_sec > ref_sec) ||
                      ((cur_sec == ref_sec) && (cur_ns >= ref_ns));

  assign prev_sec_inc = prev_sec + TIME_WIDTH_SEC'(1);

  // Only a step of zero or exactly one second can cross; larger forward
  // steps and any backward step fall through both terms.
  assign same_sec_cross = (cur_sec == prev_sec) && (prev_ns < phase_ns);
  assign next_sec_cross = (cur_sec == prev_sec_inc);

  assign crossing = sample_ok && prev_ok && (cur_ns >= phase_ns) &&
                    (same_sec_cross || next_sec_cross);

endmodule

// File: rtl/tod_pps_gen.sv
// tod_pps_gen: generates a 1PPS-style pulse from the running time of day.
//   clk, rst          : system clock, asynchronous active-high reset
//   tod_vld           : tod_ns/tod_sec valid this cycle
//   tod_ns, tod_sec   : current time of day
//   tod_jump          : ToD was set/offset/stepped this cycle
//   pps_en            : enable
//   pps_phase_ns      : edge position within the second
//   pps_width_ns      : pulse high time
//   pps_period_log2   : pulse every 2^N seconds
//   pps_out           : registered pulse output
//   pps_evt           : one-cycle strobe on each pulse start
//   pps_sec           : tod_sec captured at the trigger
//   pps_late_ns       : tod_ns - phase at the trigger (mod NS_PER_SEC)
//   cfg_err           : combinational, configuration is illegal
module tod_pps_gen
  import tod_pkg::*;
#(
  parameter int     TIME_WIDTH_NS  = tod_pkg::TIME_WIDTH_NS,
  parameter int     TIME_WIDTH_SEC = tod_pkg::TIME_WIDTH_SEC,
  parameter longint NS_PER_SEC     = tod_pkg::NS_PER_SEC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tod_vld,
  input  logic [TIME_WIDTH_NS-1:0]  tod_ns,
  input  logic [TIME_WIDTH_SEC-1:0] tod_sec,
  input  logic                      tod_jump,
  input  logic                      pps_en,
  input  logic [TIME_WIDTH_NS-1:0]  pps_phase_ns,
  input  logic [TIME_WIDTH_NS-1:0]  pps_width_ns,
  input  logic [2:0]                pps_period_log2,
  output logic                      pps_out,
  output logic                      pps_evt,
  output logic [TIME_WIDTH_SEC-1:0] pps_sec,
  output logic [TIME_WIDTH_NS-1:0]  pps_late_ns,
  output logic                      cfg_err
);

  localparam logic [TIME_WIDTH_NS:0] NS_ROLL = NS_PER_SEC[TIME_WIDTH_NS:0];

  pps_state_t                state;
  logic [TIME_WIDTH_NS-1:0]  prev_ns;
  logic [TIME_WIDTH_SEC-1:0] prev_sec;
  logic                      prev_ok;
  logic [TIME_WIDTH_NS-1:0]  end_ns;
  logic [TIME_WIDTH_SEC-1:0] end_sec;

  logic                      crossing;
  logic                      end_reached;
  logic [7:0]                period_mask;
  logic                      period_hit;
  logic                      trigger;
  logic                      start_pulse;
  logic [TIME_WIDTH_NS:0]    end_sum;
  logic [TIME_WIDTH_NS:0]    end_wrapped;
  logic                      end_wrap;
  logic [TIME_WIDTH_NS-1:0]  end_ns_next;
  logic [TIME_WIDTH_SEC-1:0] end_sec_next;
  logic [TIME_WIDTH_NS:0]    late_sum;
  logic [TIME_WIDTH_NS-1:0]  late_next;

  assign cfg_err = ({1'b0, pps_phase_ns} >= NS_ROLL) ||
                   (pps_width_ns == '0) ||
                   ({1'b0, pps_width_ns} >= NS_ROLL);

  tod_cmp #(
    .TIME_WIDTH_NS (TIME_WIDTH_NS),
    .TIME_WIDTH_SEC(TIME_WIDTH_SEC)
  ) u_cmp (
    .cur_sec   (tod_sec),
    .cur_ns    (tod_ns),
    .ref_sec   (end_sec),
    .ref_ns    (end_ns),
    .cur_ge_ref(end_reached),
    .prev_sec  (prev_sec),
    .prev_ns   (prev_ns),
    .prev_ok   (prev_ok),
    .sample_ok (tod_vld && !tod_jump),
    .phase_ns  (pps_phase_ns),
    .crossing  (crossing)
  );

  // Low period_log2 bits of the second must be zero for the pulse to fire.
  assign period_mask = 8'((9'd1 << pps_period_log2) - 9'd1);
  assign period_hit  = (tod_sec[7:0] & period_mask) == 8'd0;
  assign trigger     = crossing && period_hit;

  // Back-to-back restarts are suppressed so pps_evt never stretches.
  assign start_pulse = trigger &&
                       ((state == ARMED) || ((state == HIGH) && !pps_evt));

  // End time is phase+width, carried into the next second when it wraps.
  assign end_sum      = {1'b0, pps_phase_ns} + {1'b0, pps_width_ns};
  assign end_wrap     = end_sum >= NS_ROLL;
  assign end_wrapped  = end_sum - NS_ROLL;
  assign end_ns_next  = end_wrap ? end_wrapped[TIME_WIDTH_NS-1:0]
                                 : end_sum[TIME_WIDTH_NS-1:0];
  assign end_sec_next = end_wrap ? tod_sec + TIME_WIDTH_SEC'(1) : tod_sec;

  // Lateness modulo one second; a borrow adds NS_PER_SEC back in.
  assign late_sum  = {1'b0, tod_ns} - {1'b0, pps_phase_ns} +
                     ((tod_ns >= pps_phase_ns) ? '0 : NS_ROLL);
  assign late_next = late_sum[TIME_WIDTH_NS-1:0];

  // Last valid sample; crossing detection re-arms after a jump or IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ns  <= '0;
      prev_sec <= '0;
      prev_ok  <= 1'b0;
    end else begin
      if (tod_vld) begin
        prev_ns  <= tod_ns;
        prev_sec <= tod_sec;
      end
      if (tod_jump || (state == IDLE)) begin
        prev_ok <= 1'b0;
      end else if (tod_vld) begin
        prev_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pps_out     <= 1'b0;
      pps_evt     <= 1'b0;
      pps_sec     <= '0;
      pps_late_ns <= '0;
      end_ns      <= '0;
      end_sec     <= '0;
    end else begin
      pps_evt <= 1'b0;
      if (!pps_en || cfg_err) begin
        state   <= IDLE;
        pps_out <= 1'b0;
      end else if (start_pulse) begin
        state       <= HIGH;
        pps_out     <= 1'b1;
        pps_evt     <= 1'b1;
        pps_sec     <= tod_sec;
        pps_late_ns <= late_next;
        end_ns      <= end_ns_next;
        end_sec     <= end_sec_next;
      end else begin
        case (state)
          IDLE: begin
            state   <= ARMED;
            pps_out <= 1'b0;
          end
          ARMED: begin
            pps_out <= 1'b0;
          end
          HIGH: begin
            if (tod_jump || (tod_vld && end_reached)) begin
              state   <= ARMED;
              pps_out <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            pps_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tod_pps_gen.sv
// tb_tod_pps_gen: directed testbench for tod_pps_gen. A table of ToD
// samples with hand-computed outputs covers the basic pulse; short
// hand-written sequences cover rollover, period gating, jumps, config
// errors, enable drop and asynchronous reset.
module tb_tod_pps_gen;

  logic        clk;
  logic        rst;
  logic        tod_vld;
  logic [31:0] tod_ns;
  logic [47:0] tod_sec;
  logic        tod_jump;
  logic        pps_en;
  logic [31:0] pps_phase_ns;
  logic [31:0] pps_width_ns;
  logic [2:0]  pps_period_log2;
  logic        pps_out;
  logic        pps_evt;
  logic [47:0] pps_sec;
  logic [31:0] pps_late_ns;
  logic        cfg_err;

  int total;
  int bad;

  typedef struct {
    logic        vld;
    logic        jump;
    logic [47:0] sec;
    logic [31:0] ns;
    logic        exp_out;
    logic        exp_evt;
    logic [47:0] exp_sec;
    logic [31:0] exp_late;
  } vec_t;

  vec_t vecs[11];

  tod_pps_gen dut (
    .clk            (clk),
    .rst            (rst),
    .tod_vld        (tod_vld),
    .tod_ns         (tod_ns),
    .tod_sec        (tod_sec),
    .tod_jump       (tod_jump),
    .pps_en         (pps_en),
    .pps_phase_ns   (pps_phase_ns),
    .pps_width_ns   (pps_width_ns),
    .pps_period_log2(pps_period_log2),
    .pps_out        (pps_out),
    .pps_evt        (pps_evt),
    .pps_sec        (pps_sec),
    .pps_late_ns    (pps_late_ns),
    .cfg_err        (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic exp_out,
                          input logic exp_evt, input logic [47:0] exp_sec,
                          input logic [31:0] exp_late);
    checkOutput({name, ".out"},  64'(pps_out),     64'(exp_out));
    checkOutput({name, ".evt"},  64'(pps_evt),     64'(exp_evt));
    checkOutput({name, ".sec"},  64'(pps_sec),     64'(exp_sec));
    checkOutput({name, ".late"}, 64'(pps_late_ns), 64'(exp_late));
  endtask

  // Drive one sample before a rising edge; outputs are read 1 time unit
  // after that edge.
  task automatic applyStimulus(input logic vld, input logic jump,
                               input logic [47:0] sec, input logic [31:0] ns);
    @(negedge clk);
    tod_vld  = vld;
    tod_jump = jump;
    tod_sec  = sec;
    tod_ns   = ns;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, tod_sec, tod_ns);
  endtask

  // Reset, then one clock so an enabled, legal config reaches ARMED.
  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    tod_vld  = 1'b0;
    tod_jump = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic setCfg(input logic [31:0] phase, input logic [31:0] width,
                        input logic [2:0] lg2);
    pps_phase_ns    = phase;
    pps_width_ns    = width;
    pps_period_log2 = lg2;
  endtask

  initial begin
    int evt_count;
    total = 0;
    bad   = 0;

    rst      = 1'b1;
    tod_vld  = 1'b0;
    tod_jump = 1'b0;
    tod_ns   = '0;
    tod_sec  = '0;
    pps_en   = 1'b1;
    setCfg(32'd500000000, 32'd100000000, 3'd0);

    // Reset values
    @(posedge clk);
    #1;
    checkAll("reset", 1'b0, 1'b0, 48'd0, 32'd0);
    checkOutput("reset.cfg_err", 64'(cfg_err), 64'd0);

    // Basic crossing, phase 0.5 s, width 0.1 s
    vecs[0]  = '{1'b1, 1'b0, 48'd5, 32'd499999984, 1'b0, 1'b0, 48'd0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 48'd5, 32'd499999992, 1'b0, 1'b0, 48'd0, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, 48'd5, 32'd500000000, 1'b1, 1'b1, 48'd5, 32'd0};
    vecs[3]  = '{1'b1, 1'b0, 48'd5, 32'd500000008, 1'b1, 1'b0, 48'd5, 32'd0};
    vecs[4]  = '{1'b0, 1'b0, 48'd5, 32'd600000016, 1'b1, 1'b0, 48'd5, 32'd0};
    vecs[5]  = '{1'b1, 1'b0, 48'd5, 32'd599999992, 1'b1, 1'b0, 48'd5, 32'd0};
    vecs[6]  = '{1'b1, 1'b0, 48'd5, 32'd600000000, 1'b0, 1'b0, 48'd5, 32'd0};
    vecs[7]  = '{1'b1, 1'b0, 48'd5, 32'd600000008, 1'b0, 1'b0, 48'd5, 32'd0};
    vecs[8]  = '{1'b1, 1'b0, 48'd6, 32'd400000000, 1'b0, 1'b0, 48'd5, 32'd0};
    vecs[9]  = '{1'b1, 1'b0, 48'd6, 32'd500000004, 1'b1, 1'b1, 48'd6, 32'd4};
    vecs[10] = '{1'b1, 1'b0, 48'd6, 32'd500000012, 1'b1, 1'b0, 48'd6, 32'd4};

    doReset();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].jump, vecs[i].sec, vecs[i].ns);
      checkAll($sformatf("basic[%0d]", i), vecs[i].exp_out, vecs[i].exp_evt,
               vecs[i].exp_sec, vecs[i].exp_late);
    end

    // Pulse spanning a second boundary; end lands at (8, 1000)
    $display("[TB] second-boundary pulse");
    setCfg(32'd999999000, 32'd2000, 3'd0);
    doReset();
    applyStimulus(1'b1, 1'b0, 48'd7, 32'd999998992);
    checkAll("wrap.prime", 1'b0, 1'b0, 48'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd7, 32'd999999000);
    checkAll("wrap.rise", 1'b1, 1'b1, 48'd7, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd7, 32'd999999500);
    checkAll("wrap.hold1", 1'b1, 1'b0, 48'd7, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd8, 32'd0);
    checkAll("wrap.hold2", 1'b1, 1'b0, 48'd7, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd8, 32'd996);
    checkAll("wrap.hold3", 1'b1, 1'b0, 48'd7, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd8, 32'd1000);
    checkAll("wrap.fall", 1'b0, 1'b0, 48'd7, 32'd0);

    // Phase 0, the edge is only seen after the rollover
    $display("[TB] rollover trigger");
    setCfg(32'd0, 32'd100, 3'd0);
    doReset();
    applyStimulus(1'b1, 1'b0, 48'd3, 32'd999999992);
    checkAll("roll.prime", 1'b0, 1'b0, 48'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd3, 32'd999999996);
    checkAll("roll.before", 1'b0, 1'b0, 48'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd4, 32'd4);
    checkAll("roll.rise", 1'b1, 1'b1, 48'd4, 32'd4);
    applyStimulus(1'b1, 1'b0, 48'd4, 32'd100);
    checkAll("roll.fall", 1'b0, 1'b0, 48'd4, 32'd4);

    // Period gating, every 4 s
    $display("[TB] period gating");
    setCfg(32'd500000000, 32'd100000000, 3'd2);
    doReset();
    evt_count = 0;
    for (int s = 0; s < 10; s++) begin
      applyStimulus(1'b1, 1'b0, 48'(s), 32'd400000000);
      checkOutput($sformatf("gate[%0d].pre_evt", s), 64'(pps_evt), 64'd0);
      checkOutput($sformatf("gate[%0d].pre_out", s), 64'(pps_out), 64'd0);
      applyStimulus(1'b1, 1'b0, 48'(s), 32'd600000000);
      checkOutput($sformatf("gate[%0d].evt", s), 64'(pps_evt),
                  64'((s % 4) == 0));
      if (pps_evt) begin
        evt_count++;
        checkOutput($sformatf("gate[%0d].sec", s), 64'(pps_sec), 64'(s));
        checkOutput($sformatf("gate[%0d].late", s), 64'(pps_late_ns),
                    64'd100000000);
      end
    end
    checkOutput("gate.count", 64'(evt_count), 64'd3);

    // Backward jump mid-pulse; width changed mid-pulse has no effect
    $display("[TB] jump");
    setCfg(32'd500000000, 32'd400000000, 3'd0);
    doReset();
    applyStimulus(1'b1, 1'b0, 48'd10, 32'd490000000);
    applyStimulus(1'b1, 1'b0, 48'd10, 32'd500000000);
    checkAll("jump.rise", 1'b1, 1'b1, 48'd10, 32'd0);
    pps_width_ns = 32'd1;
    applyStimulus(1'b1, 1'b0, 48'd10, 32'd700000000);
    checkAll("jump.hold", 1'b1, 1'b0, 48'd10, 32'd0);
    pps_width_ns = 32'd400000000;
    applyStimulus(1'b1, 1'b1, 48'd10, 32'd100000000);
    checkAll("jump.drop", 1'b0, 1'b0, 48'd10, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd10, 32'd200000000);
    checkAll("jump.rearm", 1'b0, 1'b0, 48'd10, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd10, 32'd400000000);
    checkAll("jump.below", 1'b0, 1'b0, 48'd10, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd10, 32'd500000016);
    checkAll("jump.refire", 1'b1, 1'b1, 48'd10, 32'd16);

    // Illegal configurations
    $display("[TB] config and enable");
    setCfg(32'd500000000, 32'd0, 3'd0);
    doReset();
    checkOutput("cfg.width0", 64'(cfg_err), 64'd1);
    applyStimulus(1'b1, 1'b0, 48'd20, 32'd400000000);
    applyStimulus(1'b1, 1'b0, 48'd20, 32'd500000000);
    checkAll("cfg.no_pulse", 1'b0, 1'b0, 48'd0, 32'd0);
    setCfg(32'd1000000000, 32'd100000000, 3'd0);
    #1 checkOutput("cfg.phase_big", 64'(cfg_err), 64'd1);
    setCfg(32'd500000000, 32'd1000000000, 3'd0);
    #1 checkOutput("cfg.width_big", 64'(cfg_err), 64'd1);
    setCfg(32'd500000000, 32'd999999999, 3'd0);
    #1 checkOutput("cfg.width_max", 64'(cfg_err), 64'd0);
    setCfg(32'd500000000, 32'd100000000, 3'd0);
    #1 checkOutput("cfg.legal", 64'(cfg_err), 64'd0);

    // Enable dropped mid-pulse, then IDLE must have cleared prev_ok
    idleCycle();
    applyStimulus(1'b1, 1'b0, 48'd21, 32'd400000000);
    applyStimulus(1'b1, 1'b0, 48'd21, 32'd500000000);
    checkAll("en.rise", 1'b1, 1'b1, 48'd21, 32'd0);
    pps_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 48'd21, 32'd510000000);
    checkAll("en.drop", 1'b0, 1'b0, 48'd21, 32'd0);
    pps_en = 1'b1;
    idleCycle();
    applyStimulus(1'b1, 1'b0, 48'd22, 32'd550000000);
    checkAll("en.no_stale", 1'b0, 1'b0, 48'd21, 32'd0);
    applyStimulus(1'b1, 1'b0, 48'd22, 32'd560000000);
    checkAll("en.armed", 1'b0, 1'b0, 48'd21, 32'd0);

    // Asynchronous reset mid-pulse
    applyStimulus(1'b1, 1'b0, 48'd23, 32'd400000000);
    applyStimulus(1'b1, 1'b0, 48'd23, 32'd500000000);
    checkAll("rst.rise", 1'b1, 1'b1, 48'd23, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkAll("rst.async", 1'b0, 1'b0, 48'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
